// File: rtl/timer_prog_if.sv
// rtl/timer_prog_if.sv - threshold configuration bus for the programmable phase timer
interface timer_prog_if #(
    parameter int CNT_W = 8
);
    logic             cfg_wr;
    logic             cfg_sel;
    logic [CNT_W-1:0] cfg_data;

    modport master (
        output cfg_wr,
        output cfg_sel,
        output cfg_data
    );

    modport slave (
        input cfg_wr,
        input cfg_sel,
        input cfg_data
    );
endinterface

// File: rtl/timer_prog.sv
// rtl/timer_prog.sv - programmable phase timer with short/long thresholds, pause,
// one-shot/periodic modes and a one-cycle expiry pulse
module timer_prog #(
    parameter int CNT_W     = 8,
    parameter int SHORT_DEF = 3,
    parameter int LONG_DEF  = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             timer_hw_reset,
    input  logic             timer_fw_reset,
    input  logic             enable,
    input  logic             periodic,
    timer_prog_if.slave      cfg,
    output logic [CNT_W-1:0] count,
    output logic             short_timeout,
    output logic             long_timeout,
    output logic             expire_pulse
);
    logic [CNT_W-1:0] short_thr;
    logic [CNT_W-1:0] long_thr;
    logic             armed;
    logic             restart;
    logic             at_long;
    logic             hit;

    assign restart = timer_hw_reset | timer_fw_reset;
    assign at_long = (count >= long_thr);
    assign hit     = !restart && enable && at_long;

    assign long_timeout  = at_long;
    assign short_timeout = (count >= short_thr) | at_long;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (!enable) begin
            count <= count;
        end else if (at_long) begin
            count <= periodic ? '0 : count;
        end else begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            short_thr <= CNT_W'(SHORT_DEF);
            long_thr  <= CNT_W'(LONG_DEF);
        end else if (cfg.cfg_wr) begin
            if (cfg.cfg_sel) begin
                long_thr <= cfg.cfg_data;
            end else begin
                short_thr <= cfg.cfg_data;
            end
        end
    end

    // armed drops once a one-shot expiry has been reported and comes back on
    // restart or when count falls below long_thr (e.g. after a wrap).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed        <= 1'b1;
            expire_pulse <= 1'b0;
        end else begin
            armed        <= restart || !at_long || (armed && !hit);
            expire_pulse <= hit && (periodic || armed);
        end
    end
endmodule

// File: tb/tb_timer_prog.sv
// tb/tb_timer_prog.sv - self-checking bench for timer_prog with reference model
module tb_timer_prog;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             timer_hw_reset = 1'b0;
    logic             timer_fw_reset = 1'b0;
    logic             enable = 1'b0;
    logic             periodic = 1'b0;
    logic [CNT_W-1:0] count;
    logic             short_timeout;
    logic             long_timeout;
    logic             expire_pulse;

    timer_prog_if #(.CNT_W(CNT_W)) cfg_bus ();

    timer_prog #(.CNT_W(CNT_W), .SHORT_DEF(3), .LONG_DEF(7)) dut (
        .clk            (clk),
        .reset          (reset),
        .timer_hw_reset (timer_hw_reset),
        .timer_fw_reset (timer_fw_reset),
        .enable         (enable),
        .periodic       (periodic),
        .cfg            (cfg_bus.slave),
        .count          (count),
        .short_timeout  (short_timeout),
        .long_timeout   (long_timeout),
        .expire_pulse   (expire_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;
    int pulse_cnt = 0;
    int long_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count, thresholds and "expiry already reported" flag
    int m_count = 0;
    int m_short = 3;
    int m_long  = 7;
    bit m_fired = 1'b0;
    bit m_pulse = 1'b0;
    bit m_restart;
    bit m_hit;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_count = 0;
            m_short = 3;
            m_long  = 7;
            m_fired = 1'b0;
            m_pulse = 1'b0;
        end else begin
            m_restart = timer_hw_reset || timer_fw_reset;
            m_hit     = !m_restart && enable && (m_count >= m_long);
            m_pulse   = m_hit && (periodic || !m_fired);
            if (m_restart || m_count < m_long) m_fired = 1'b0;
            else if (m_hit) m_fired = 1'b1;
            if (m_restart) m_count = 0;
            else if (enable && m_count < m_long) m_count = m_count + 1;
            else if (enable && periodic) m_count = 0;
            if (cfg_bus.cfg_wr) begin
                if (cfg_bus.cfg_sel) m_long = int'(cfg_bus.cfg_data);
                else m_short = int'(cfg_bus.cfg_data);
            end
        end
    end

    always @(negedge clk) begin
        if (expire_pulse) pulse_cnt++;
        if (long_timeout) long_cnt++;
        if (chk_en) begin
            chk("model_count", int'(count), m_count);
            chk("model_short", int'(short_timeout), int'((m_count >= m_short) || (m_count >= m_long)));
            chk("model_long", int'(long_timeout), int'(m_count >= m_long));
            chk("model_pulse", int'(expire_pulse), int'(m_pulse));
        end
    end

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) next();
    endtask

    task automatic restart_fw();
        timer_fw_reset = 1'b1;
        next();
        timer_fw_reset = 1'b0;
    endtask

    task automatic cfg_write(input bit sel, input int data);
        cfg_bus.cfg_wr   = 1'b1;
        cfg_bus.cfg_sel  = sel;
        cfg_bus.cfg_data = CNT_W'(data);
        next();
        cfg_bus.cfg_wr = 1'b0;
    endtask

    task automatic async_reset_check(input string tag);
        #1;
        reset = 1'b0;
        #1;
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_short"}, int'(short_timeout), 0);
        chk({tag, "_long"}, int'(long_timeout), 0);
        chk({tag, "_pulse"}, int'(expire_pulse), 0);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        cfg_bus.cfg_wr   = 1'b0;
        cfg_bus.cfg_sel  = 1'b0;
        cfg_bus.cfg_data = '0;

        next();
        chk("rst_count", int'(count), 0);
        chk("rst_short", int'(short_timeout), 0);
        chk("rst_long", int'(long_timeout), 0);
        chk("rst_pulse", int'(expire_pulse), 0);

        // Legacy timing with defaults, one-shot
        reset = 1'b1;
        enable = 1'b1;
        chk_en = 1'b1;
        timer_hw_reset = 1'b1;
        next();
        timer_hw_reset = 1'b0;
        pulse_cnt = 0;
        step_n(2);
        chk("t1_short_before", int'(short_timeout), 0);
        next();
        chk("t1_count3", int'(count), 3);
        chk("t1_short3", int'(short_timeout), 1);
        chk("t1_long3", int'(long_timeout), 0);
        step_n(4);
        chk("t1_count7", int'(count), 7);
        chk("t1_long7", int'(long_timeout), 1);
        step_n(20);
        chk("t1_count_hold", int'(count), 7);
        chk("t1_pulses", pulse_cnt, 1);

        // Restart from firmware and hardware at count 5
        restart_fw();
        step_n(5);
        timer_fw_reset = 1'b1;
        next();
        timer_fw_reset = 1'b0;
        chk("t2_fw_count", int'(count), 0);
        chk("t2_fw_short", int'(short_timeout), 0);
        step_n(3);
        chk("t2_fw_short3", int'(short_timeout), 1);
        step_n(2);
        timer_hw_reset = 1'b1;
        next();
        timer_hw_reset = 1'b0;
        chk("t2_hw_count", int'(count), 0);
        step_n(3);
        chk("t2_hw_short3", int'(short_timeout), 1);

        // Pause at count 2
        restart_fw();
        step_n(2);
        enable = 1'b0;
        step_n(10);
        chk("t3_count_hold", int'(count), 2);
        chk("t3_short_hold", int'(short_timeout), 0);
        enable = 1'b1;
        next();
        chk("t3_short_resume", int'(short_timeout), 1);

        // Programmed thresholds 12/20, then long lowered below count
        cfg_write(1'b1, 20);
        cfg_write(1'b0, 12);
        restart_fw();
        step_n(11);
        chk("t4_short11", int'(short_timeout), 0);
        next();
        chk("t4_short12", int'(short_timeout), 1);
        chk("t4_long12", int'(long_timeout), 0);
        step_n(8);
        chk("t4_count20", int'(count), 20);
        chk("t4_long20", int'(long_timeout), 1);
        restart_fw();
        step_n(9);
        enable = 1'b0;
        cfg_write(1'b1, 4);
        chk("t4_long_now", int'(long_timeout), 1);
        enable = 1'b1;
        next();
        chk("t4_count_hold9", int'(count), 9);

        // Periodic with long=5
        cfg_write(1'b1, 5);
        periodic = 1'b1;
        restart_fw();
        pulse_cnt = 0;
        long_cnt = 0;
        step_n(18);
        chk("t5_pulses", pulse_cnt, 3);
        chk("t5_long_cycles", long_cnt, 3);

        // Asynchronous reset at count 6, then defaults in effect again
        periodic = 1'b0;
        cfg_write(1'b1, 9);
        restart_fw();
        step_n(6);
        chk("t6_count6", int'(count), 6);
        async_reset_check("t6");
        restart_fw();
        step_n(3);
        chk("t6_def_short", int'(short_timeout), 1);
        step_n(4);
        chk("t6_def_long", int'(long_timeout), 1);

        // Randomized traffic checked by the model every cycle
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int r;
            r = $urandom_range(0, 99);
            timer_hw_reset = (r < 3);
            timer_fw_reset = (r >= 3 && r < 6);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 63) == 0) periodic = ~periodic;
            cfg_bus.cfg_wr  = ($urandom_range(0, 11) == 0);
            cfg_bus.cfg_sel = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 31) == 0) cfg_bus.cfg_data = CNT_W'($urandom_range(0, 255));
            else cfg_bus.cfg_data = CNT_W'($urandom_range(0, 12));
            if ($urandom_range(0, 499) == 0) async_reset_check("rnd_async");
            next();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
